// File: rtl/lcd_pkg.sv
// lcd_pkg: shared controller states, strobe phases, HD44780 command bytes and
// the rule that replaces unprintable characters with a blank.
package lcd_pkg;
  typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, SET_ADDR, LOAD, WRITE, CLR_WAIT} state_e;
  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_STROBE, PH_HOLD} phase_e;
  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_DDRAM0   = 8'h80;
  localparam logic [7:0] CHAR_SUB     = 8'h20;
  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    return i == 2'd0 ? CMD_FUNC_SET : i == 2'd1 ? CMD_DISP_ON : i == 2'd2 ? CMD_ENTRY : CMD_CLEAR;
  endfunction
  function automatic logic [7:0] lcd_char(input logic [7:0] c);
    return (c < 8'h20 || c > 8'h7E) ? CHAR_SUB : c;
  endfunction
endpackage

// File: rtl/lcd_strobe_gen.sv
// lcd_strobe_gen: one LCD bus transaction as setup / E-high / hold phases of
// STEP_CYC cycles each; done marks the last hold cycle so a new start can follow back-to-back.
module lcd_strobe_gen import lcd_pkg::*; #(
  parameter int STEP_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done,
  output logic lcd_e
);
  localparam int SW = $clog2(STEP_CYC);
  localparam logic [SW-1:0] LAST = SW'(STEP_CYC - 1);
  phase_e ph_q, ph_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic e_q, e_d, last;
  always_comb begin
    last = cnt_q == LAST;
    done = ph_q == PH_HOLD && last;
    cnt_d = (start || ph_q == PH_IDLE || last) ? '0 : cnt_q + 1'b1;
    ph_d = start ? PH_SETUP :
           (!last || ph_q == PH_IDLE) ? ph_q :
           ph_q == PH_SETUP ? PH_STROBE :
           ph_q == PH_STROBE ? PH_HOLD : PH_IDLE;
    e_d = ph_d == PH_STROBE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ph_q <= PH_IDLE;
      cnt_q <= '0;
      e_q <= 1'b0;
    end else begin
      ph_q <= ph_d;
      cnt_q <= cnt_d;
      e_q <= e_d;
    end
  end
  assign lcd_e = e_q;
endmodule

// File: rtl/lcd_refresh_ctrl.sv
// lcd_refresh_ctrl: powers up and initialises an HD44780-style LCD, then rewrites
// the 16-character line from the external store whenever an update is requested.
module lcd_refresh_ctrl import lcd_pkg::*; #(
  parameter int STEP_CYC     = 4,
  parameter int PWR_WAIT_CYC = 750000,
  parameter int CLR_WAIT_CYC = 80000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       update_req,
  output logic [3:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       busy
);
  localparam int WAIT_MAX = PWR_WAIT_CYC > CLR_WAIT_CYC ? PWR_WAIT_CYC : CLR_WAIT_CYC;
  localparam int CW = WAIT_MAX > 1 ? $clog2(WAIT_MAX) : 1;
  localparam logic [CW-1:0] PWR_LAST = CW'(PWR_WAIT_CYC - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT_CYC - 1);
  state_e state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [1:0] cmd_q, cmd_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic rs_q, rs_d, pend_q, pend_d, busy_q, busy_d;
  logic start, done, go_ref;
  lcd_strobe_gen #(.STEP_CYC(STEP_CYC)) u_strobe (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .done (done),
    .lcd_e(lcd_e)
  );
  always_comb begin
    state_d = state_q;
    wait_d = wait_q;
    cmd_d = cmd_q;
    addr_d = addr_q;
    data_d = data_q;
    rs_d = rs_q;
    pend_d = pend_q | update_req;
    start = 1'b0;
    go_ref = 1'b0;
    case (state_q)
      PWR_WAIT: begin
        wait_d = wait_q == PWR_LAST ? '0 : wait_q + 1'b1;
        if (wait_q == PWR_LAST) begin
          state_d = INIT;
          start = 1'b1;
          cmd_d = 2'd0;
          rs_d = 1'b0;
          data_d = CMD_FUNC_SET;
        end
      end
      INIT: if (done) begin
        if (cmd_q == 2'd3) state_d = CLR_WAIT;
        else begin
          start = 1'b1;
          cmd_d = cmd_q + 2'd1;
          data_d = init_cmd(cmd_q + 2'd1);
        end
      end
      CLR_WAIT: begin
        wait_d = wait_q == CLR_LAST ? '0 : wait_q + 1'b1;
        go_ref = wait_q == CLR_LAST;
      end
      IDLE: go_ref = pend_q;
      SET_ADDR: if (done) begin
        state_d = LOAD;
        addr_d = 4'd0;
      end
      LOAD: begin
        state_d = WRITE;
        start = 1'b1;
        rs_d = 1'b1;
        data_d = lcd_char(rd_data);
      end
      WRITE: if (done) begin
        if (addr_q == 4'hF) begin
          state_d = IDLE;
          go_ref = pend_q;
        end else begin
          state_d = LOAD;
          addr_d = addr_q + 4'd1;
        end
      end
      default: state_d = PWR_WAIT;
    endcase
    // a request arriving on the very entry cycle survives and forces one more refresh
    if (go_ref) begin
      state_d = SET_ADDR;
      start = 1'b1;
      rs_d = 1'b0;
      data_d = CMD_DDRAM0;
      pend_d = update_req;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PWR_WAIT;
      wait_q <= '0;
      cmd_q <= 2'd0;
      addr_q <= 4'd0;
      data_q <= 8'h00;
      rs_q <= 1'b0;
      pend_q <= 1'b0;
      busy_q <= 1'b1;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      cmd_q <= cmd_d;
      addr_q <= addr_d;
      data_q <= data_d;
      rs_q <= rs_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
    end
  end
  assign rd_addr = addr_q;
  assign lcd_rs = rs_q;
  assign lcd_rw = 1'b0;
  assign lcd_data = data_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// tb_lcd_refresh_ctrl: timeline model of boot and refresh schedules checked every
// cycle, plus literal checks on E-high samples, refresh length and reset behaviour.
module tb_lcd_refresh_ctrl;
  localparam int S = 4, PW = 20, CL = 40;
  localparam int TX = 3 * S, BOOT = PW + 4 * TX + CL, REF = TX + 16 * (TX + 1);
  logic clk = 1'b0, reset = 1'b1, update_req = 1'b0;
  logic [3:0] rd_addr;
  logic [7:0] rd_data, lcd_data;
  logic lcd_e, lcd_rs, lcd_rw, busy;
  logic [7:0] store [16];
  logic [7:0] init_cmds [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
  int checks = 0, failures = 0;
  int t = 0, ref_start = -1;
  bit idle = 0, pend = 0, model_ok = 0, prev_e = 0;
  logic [7:0] cur_char = 8'h00;
  logic [7:0] rise_data [$];
  bit rise_rs [$];
  int rise_t [$];

  assign rd_data = store[rd_addr];

  lcd_refresh_ctrl #(.STEP_CYC(S), .PWR_WAIT_CYC(PW), .CLR_WAIT_CYC(CL)) dut (
    .clk(clk), .reset(reset), .update_req(update_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%0h want=%0h", name, t, act, exp);
    end
  endtask

  function automatic bit txn_e(input int p);
    return p >= S && p < 2 * S;
  endfunction

  function automatic logic [7:0] shown(input logic [7:0] c);
    return (c >= 8'h20 && c <= 8'h7E) ? c : 8'h20;
  endfunction

  function automatic logic [31:0] rd(input int i);
    return i < rise_data.size() ? 32'(rise_data[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] rrs(input int i);
    return i < rise_rs.size() ? 32'(rise_rs[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] rt(input int i);
    return i < rise_t.size() ? rise_t[i] : -1;
  endfunction

  // schedule model: boot timeline, then refreshes of REF cycles triggered by a pending request
  always @(posedge clk) begin
    model_ok = 1;
    if (reset) begin
      t = 0; ref_start = -1; idle = 0; pend = 0;
    end else begin
      if (!idle && ref_start < 0 && t + 1 == BOOT) begin
        ref_start = t + 1; pend = update_req;
      end else if (!idle && ref_start >= 0 && t - ref_start == REF - 1) begin
        if (pend) ref_start = t + 1;
        else idle = 1;
        pend = update_req;
      end else if (idle && pend) begin
        idle = 0; ref_start = t + 1; pend = update_req;
      end else pend = pend | update_req;
      t++;
    end
  end

  always @(negedge clk) begin
    int o, k, i, r;
    if (model_ok) begin
      chk("lcd_rw", lcd_rw, 0);
      if (ref_start < 0 && !idle) begin
        chk("boot_busy", busy, 1);
        if (t < PW) begin
          chk("pwr_e", lcd_e, 0); chk("pwr_rs", lcd_rs, 0);
          chk("pwr_data", lcd_data, 0); chk("pwr_addr", rd_addr, 0);
        end else if (t < PW + 4 * TX) begin
          k = (t - PW) / TX; r = (t - PW) % TX;
          chk("init_e", lcd_e, txn_e(r)); chk("init_rs", lcd_rs, 0);
          chk("init_data", lcd_data, init_cmds[k]);
        end else chk("clr_e", lcd_e, 0);
      end else if (idle) begin
        chk("idle_busy", busy, 0); chk("idle_e", lcd_e, 0);
      end else begin
        o = t - ref_start;
        chk("ref_busy", busy, 1);
        if (o < TX) begin
          chk("addr_e", lcd_e, txn_e(o)); chk("addr_rs", lcd_rs, 0); chk("addr_data", lcd_data, 8'h80);
        end else begin
          k = o - TX; i = k / (TX + 1); r = k % (TX + 1);
          chk("rd_addr", rd_addr, i);
          if (r == 0) begin
            chk("load_e", lcd_e, 0);
            cur_char = shown(store[i]);
          end else begin
            chk("wr_e", lcd_e, txn_e(r - 1)); chk("wr_rs", lcd_rs, 1); chk("wr_data", lcd_data, cur_char);
          end
        end
      end
      if (lcd_e === 1'b1 && !prev_e) begin
        rise_data.push_back(lcd_data); rise_rs.push_back(lcd_rs === 1'b1); rise_t.push_back(t);
      end
      prev_e = lcd_e === 1'b1;
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic clear_rises;
    rise_data.delete(); rise_rs.delete(); rise_t.delete();
  endtask

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < max) begin tick(); n++; end
    checks++;
    if (n >= max) begin
      failures++;
      $display("FAIL %s busy still high after %0d cycles", name, n);
    end
  endtask

  task automatic run_refresh(input int pulse_at, output int n);
    int w = 0;
    bit sent = 0;
    update_req = 1'b1; tick(); update_req = 1'b0;
    while (busy !== 1'b1 && w < 5) begin tick(); w++; end
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      update_req = !sent && rise_data.size() == pulse_at;
      if (update_req) sent = 1;
      tick(); n++;
    end
    update_req = 1'b0;
  endtask

  initial begin
    int n;
    string hs;
    for (int i = 0; i < 16; i++) store[i] = 8'h20;
    repeat (3) tick();
    clear_rises(); reset = 1'b0;
    wait_idle(800, "boot_idle");
    chk("boot_rises", rise_data.size(), 21);
    chk("first_rise_t", rt(0), 24);
    chk("first_rise_data", rd(0), 8'h38);
    chk("first_rise_rs", rrs(0), 0);
    chk("init_cmd1", rd(1), 8'h0C);
    chk("init_cmd2", rd(2), 8'h06);
    chk("init_cmd3", rd(3), 8'h01);
    chk("boot_setaddr", rd(4), 8'h80);
    chk("clr_gap", rt(4) - rt(3), 52);

    hs = "HELLO";
    for (int i = 0; i < 16; i++) store[i] = i < 5 ? hs[i] : 8'h20;
    clear_rises();
    run_refresh(-1, n);
    chk("hello_len", n, 220);
    chk("hello_rises", rise_data.size(), 17);
    for (int i = 0; i < 17; i++) begin
      chk("hello_char", rd(i), i == 0 ? 8'h80 : i <= 5 ? hs[i-1] : 8'h20);
      chk("hello_rs", rrs(i), i != 0);
    end

    for (int i = 0; i < 16; i++) store[i] = 8'($urandom_range(8'h21, 8'h7E));
    store[3] = 8'h0D; store[9] = 8'hC1;
    clear_rises();
    run_refresh(-1, n);
    chk("sub_len", n, 220);
    chk("sub_idx3", rd(4), 8'h20);
    chk("sub_idx9", rd(10), 8'h20);
    chk("keep_idx0", rd(1), store[0]);

    clear_rises();
    run_refresh(8, n);
    chk("b2b_len", n, 440);
    chk("b2b_rises", rise_data.size(), 34);
    chk("b2b_second_cmd", rd(17), 8'h80);
    chk("b2b_gap", rt(17) - rt(16), 12);

    reset = 1'b1; tick(); clear_rises(); reset = 1'b0;
    repeat (29) tick();
    update_req = 1'b1; tick(); update_req = 1'b0;
    repeat (15) tick();
    update_req = 1'b1; tick(); update_req = 1'b0;
    wait_idle(800, "two_pulse_idle");
    repeat (60) tick();
    chk("two_pulse_rises", rise_data.size(), 21);
    chk("two_pulse_setaddr", rd(4), 8'h80);
    chk("two_pulse_busy", busy, 0);

    clear_rises();
    update_req = 1'b1; tick(); update_req = 1'b0;
    n = 0;
    while (rise_data.size() < 7 && n < 300) begin tick(); n++; end
    chk("idx5_reached", rise_data.size(), 7);
    chk("idx5_e_high", lcd_e, 1);
    reset = 1'b1; tick(); clear_rises();
    chk("rst_e_drop", lcd_e, 0);
    chk("rst_busy", busy, 1);
    reset = 1'b0;
    wait_idle(800, "reboot_idle");
    chk("reboot_rises", rise_data.size(), 21);
    chk("reboot_first_t", rt(0), 24);
    chk("reboot_first", rd(0), 8'h38);

    for (int c = 0; c < 4000; c++) begin
      update_req = $urandom_range(0, 79) == 0;
      if ($urandom_range(0, 29) == 0) store[$urandom_range(0, 15)] = 8'($urandom_range(0, 255));
      reset = $urandom_range(0, 1999) == 0;
      tick();
    end
    reset = 1'b0; update_req = 1'b0;
    wait_idle(1000, "final_idle");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
